// File: rtl/uart_wrapper_if.sv
// Command/response handshake between the UART front end (slave) and the
// command processor (master).
interface uart_wrapper_if;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    modport slave (
        output cmd_rdy, cmd, data, resp_sent,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport master (
        input  cmd_rdy, cmd, data, resp_sent,
        output clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/uart_wrapper.sv
// Remote-link UART front end: 8N1 receiver assembling 3-byte command frames,
// and a response transmitter with a one-entry pending buffer.
module uart_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RX,
    output logic          TX,
    uart_wrapper_if.slave host
);
    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} frame_state_t;
    typedef enum logic       {TX_IDLE, TX_XMIT} tx_state_t;

    // ---------------- receiver ----------------
    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_valid;
    logic          rx_fall, rx_half, rx_full;
    logic          rx_cnt_clr, rx_shift_en, rx_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking, so each flop captures its neighbour's old value
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;
    assign rx_half = (rx_cnt == HALF_LAST);
    assign rx_full = (rx_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        // NOTE: default first so no path leaves the variable unassigned (no latch)
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_full && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_full) rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_cnt_clr  = 1'b1;
        rx_shift_en = 1'b0;
        rx_accept   = 1'b0;
        case (rx_state)
            RX_IDLE:  rx_cnt_clr = 1'b1;
            RX_START: rx_cnt_clr = rx_half;
            RX_DATA: begin
                rx_cnt_clr  = rx_full;
                rx_shift_en = rx_full;
            end
            RX_STOP: begin
                rx_cnt_clr = rx_full;
                rx_accept  = rx_full & rx_sync;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_cnt   <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
            rx_valid <= rx_accept;
            if (rx_state != RX_DATA) rx_bit <= '0;
            else if (rx_shift_en)    rx_bit <= rx_bit + 1'b1;
            if (rx_shift_en) rx_shift <= {rx_sync, rx_shift[7:1]};
        end
    end

    // ---------------- frame assembly ----------------
    frame_state_t frame_state, frame_next;
    logic         ld_cmd, ld_hi, ld_lo;
    logic [7:0]   cmd_q;
    logic [15:0]  data_q;
    logic         cmd_rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_state <= WAIT_CMD;
        else        frame_state <= frame_next;
    end

    always_comb begin
        frame_next = frame_state;
        if (rx_valid) begin
            case (frame_state)
                WAIT_CMD: frame_next = WAIT_HI;
                WAIT_HI:  frame_next = WAIT_LO;
                default:  frame_next = WAIT_CMD;
            endcase
        end
    end

    always_comb begin
        ld_cmd = rx_valid && (frame_state == WAIT_CMD);
        ld_hi  = rx_valid && (frame_state == WAIT_HI);
        ld_lo  = rx_valid && (frame_state == WAIT_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            data_q    <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            if (ld_cmd) cmd_q         <= rx_shift;
            if (ld_hi)  data_q[15:8]  <= rx_shift;
            if (ld_lo)  data_q[7:0]   <= rx_shift;
            // A completing frame takes priority over a simultaneous clear.
            if (ld_lo)                          cmd_rdy_q <= 1'b1;
            else if (ld_cmd || host.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
        end
    end

    assign host.cmd     = cmd_q;
    assign host.data    = data_q;
    assign host.cmd_rdy = cmd_rdy_q;

    // ---------------- transmitter ----------------
    tx_state_t     tx_state, tx_next;
    logic [9:0]    tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          pend_valid;
    logic [7:0]    pend_byte;
    logic          tx_tick, tx_last, tx_load, pend_store;
    logic [7:0]    tx_byte;

    assign tx_tick = (tx_cnt == BAUD_LAST);
    assign tx_last = (tx_state == TX_XMIT) && tx_tick && (tx_bit == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (host.send_resp) tx_next = TX_XMIT;
            TX_XMIT: if (tx_last && !host.send_resp && !pend_valid) tx_next = TX_IDLE;
        endcase
    end

    // A request landing on the final stop-bit cycle goes straight out next,
    // replacing any older pending byte.
    always_comb begin
        tx_load        = 1'b0;
        tx_byte        = host.resp;
        pend_store     = 1'b0;
        host.resp_sent = tx_last;
        case (tx_state)
            TX_IDLE: tx_load = host.send_resp;
            TX_XMIT: begin
                pend_store = host.send_resp && !tx_last;
                if (tx_last) begin
                    tx_load = host.send_resp || pend_valid;
                    if (!host.send_resp) tx_byte = pend_byte;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift   <= '1;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            pend_valid <= 1'b0;
            pend_byte  <= '0;
        end else begin
            if (tx_load) begin
                tx_shift <= {1'b1, tx_byte, 1'b0};
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state == TX_XMIT) begin
                if (tx_tick) begin
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    tx_cnt   <= '0;
                    tx_bit   <= tx_bit + 1'b1;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
            if (pend_store) begin
                pend_valid <= 1'b1;
                pend_byte  <= host.resp;
            end else if (tx_last) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Idle shifts in ones, so the line is high straight out of reset.
    assign TX = tx_shift[0];
endmodule

// File: tb/tb_uart_wrapper.sv
// Self-checking bench for uart_wrapper: directed and random RX frames against a
// frame-queue model, and TX waveforms against a send-schedule model.
module tb_uart_wrapper;
    localparam int BAUD = 16;
    localparam int TXN  = 400;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_line;
    logic tx_line;

    uart_wrapper_if dut_if ();

    uart_wrapper #(.BAUD_DIV(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (rx_line),
        .TX    (tx_line),
        .host  (dut_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int   rdy_rises = 0;
    logic rdy_d     = 1'b0;
    always @(negedge clk) begin
        rdy_d <= dut_if.cmd_rdy;
        if (dut_if.cmd_rdy === 1'b1 && rdy_d !== 1'b1) rdy_rises <= rdy_rises + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame model: accepted bytes collect in a queue; every third closes a frame.
    logic [7:0]  m_cmd  = 8'h00;
    logic [15:0] m_data = 16'h0000;
    logic        m_rdy  = 1'b0;
    logic [7:0]  frame_q[$];

    task automatic model_reset();
        frame_q.delete();
        m_cmd  = 8'h00;
        m_data = 16'h0000;
        m_rdy  = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        frame_q.push_back(b);
        if (frame_q.size() == 1) begin
            m_cmd = b;
            m_rdy = 1'b0;
        end else if (frame_q.size() == 2) begin
            m_data[15:8] = b;
        end else begin
            m_data = {frame_q[1], frame_q[2]};
            m_rdy  = 1'b1;
            frame_q.delete();
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            repeat (BAUD) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        if (stop_bit) model_accept(b);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_cmd_rdy"}, 32'(dut_if.cmd_rdy), 32'(m_rdy));
        check({tag, "_cmd"},     32'(dut_if.cmd),     32'(m_cmd));
        check({tag, "_data"},    32'(dut_if.data),    32'(m_data));
    endtask

    task automatic clr_pulse();
        dut_if.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        dut_if.clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
    endtask

    // TX stimulus schedule: send at sample index snd_at (-1 = before sample 0).
    int         snd_at[4];
    logic [7:0] snd_b[4];
    int         snd_n;
    logic       tx_log[TXN];
    logic       rs_log[TXN];
    int         rs_pos[$];

    task automatic tx_run();
        for (int k = -1; k < TXN; k++) begin
            @(negedge clk);
            if (k >= 0) begin
                tx_log[k] = tx_line;
                rs_log[k] = dut_if.resp_sent;
            end
            dut_if.send_resp = 1'b0;
            for (int i = 0; i < snd_n; i++) begin
                if (snd_at[i] == k) begin
                    dut_if.send_resp = 1'b1;
                    dut_if.resp      = snd_b[i];
                end
            end
        end
    endtask

    // Each send takes effect on the next cycle; a busy line holds one pending
    // byte (newest wins) that starts the moment the current frame ends.
    task automatic tx_check(input string tag);
        int         fr_st[$];
        logic [7:0] fr_b[$];
        int         cur_end, s, first_bad_tx, first_bad_rs;
        logic       have_pend, e_tx, e_rs;
        logic [7:0] pend_b;
        logic [9:0] f;
        cur_end   = -100000;
        have_pend = 1'b0;
        pend_b    = 8'h00;
        for (int i = 0; i < snd_n; i++) begin
            s = snd_at[i] + 1;
            if (have_pend && s > cur_end) begin
                fr_st.push_back(cur_end);
                fr_b.push_back(pend_b);
                cur_end   = cur_end + 10 * BAUD;
                have_pend = 1'b0;
            end
            if (!have_pend && s >= cur_end) begin
                fr_st.push_back(s);
                fr_b.push_back(snd_b[i]);
                cur_end = s + 10 * BAUD;
            end else begin
                have_pend = 1'b1;
                pend_b    = snd_b[i];
            end
        end
        if (have_pend) begin
            fr_st.push_back(cur_end);
            fr_b.push_back(pend_b);
        end
        first_bad_tx = -1;
        first_bad_rs = -1;
        rs_pos.delete();
        for (int k = 0; k < TXN; k++) begin
            e_tx = 1'b1;
            e_rs = 1'b0;
            for (int j = 0; j < fr_st.size(); j++) begin
                if (k >= fr_st[j] && k < fr_st[j] + 10 * BAUD) begin
                    f    = {1'b1, fr_b[j], 1'b0};
                    e_tx = f[(k - fr_st[j]) / BAUD];
                    e_rs = (k == fr_st[j] + 10 * BAUD - 1);
                end
            end
            if (tx_log[k] !== e_tx && first_bad_tx < 0) first_bad_tx = k;
            if (rs_log[k] !== e_rs && first_bad_rs < 0) first_bad_rs = k;
            if (rs_log[k] === 1'b1) rs_pos.push_back(k);
        end
        check({tag, "_tx_first_bad_cycle"}, 32'(first_bad_tx), 32'(-1));
        check({tag, "_rs_first_bad_cycle"}, 32'(first_bad_rs), 32'(-1));
        check({tag, "_rs_pulses"}, 32'(rs_pos.size()), 32'(fr_st.size()));
    endtask

    int         base;
    logic [7:0] rb0, rb1;

    initial begin
        rx_line            = 1'b1;
        dut_if.clr_cmd_rdy = 1'b0;
        dut_if.resp        = 8'h00;
        dut_if.send_resp   = 1'b0;
        snd_n              = 0;
        rst_n              = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx",        32'(tx_line),          32'h1);
        check("reset_cmd_rdy",   32'(dut_if.cmd_rdy),   32'h0);
        check("reset_cmd",       32'(dut_if.cmd),       32'h0);
        check("reset_data",      32'(dut_if.data),      32'h0);
        check("reset_resp_sent", 32'(dut_if.resp_sent), 32'h0);
        rst_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check("idle_tx", 32'(tx_line), 32'h1);

        // Directed frame 02/12/34, hold, then clear.
        base = rdy_rises;
        rx_byte(8'h02, 1'b1); check_frame("f1_b0");
        rx_byte(8'h12, 1'b1); check_frame("f1_b1");
        rx_byte(8'h34, 1'b1); check_frame("f1_b2");
        check("f1_rdy_rises", 32'(rdy_rises - base), 32'd1);
        repeat (40) @(negedge clk);
        check("f1_rdy_hold", 32'(dut_if.cmd_rdy), 32'h1);
        clr_pulse();
        check_frame("f1_cleared");

        // Random frames; odd frames stay set so the next opcode must clear them.
        for (int fr = 0; fr < 3; fr++) begin
            for (int b = 0; b < 3; b++) begin
                rx_byte(8'($urandom), 1'b1);
                check_frame($sformatf("rnd%0d_b%0d", fr, b));
            end
            if (fr % 2 == 0) begin
                clr_pulse();
                check_frame($sformatf("rnd%0d_clr", fr));
            end
        end

        // Framing error on byte 1 is dropped without disturbing assembly.
        rx_byte(8'($urandom), 1'b1);
        rx_byte(8'($urandom), 1'b0);
        check_frame("fe_bad");
        rx_byte(8'h56, 1'b1);
        rx_byte(8'($urandom), 1'b1);
        check_frame("fe_done");
        clr_pulse();

        // Short low glitch mid-frame is not a byte.
        rx_byte(8'($urandom), 1'b1);
        rx_line = 1'b0;
        repeat (4) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check_frame("glitch");
        rx_byte(8'($urandom), 1'b1);
        rx_byte(8'($urandom), 1'b1);
        check_frame("glitch_done");
        clr_pulse();

        // Clear held high while the last byte completes: the set still lands.
        rx_byte(8'($urandom), 1'b1);
        rx_byte(8'($urandom), 1'b1);
        base = rdy_rises;
        dut_if.clr_cmd_rdy = 1'b1;
        rx_byte(8'($urandom), 1'b1);
        m_rdy = 1'b0;
        check("sc_rdy_rises", 32'(rdy_rises - base), 32'd1);
        check_frame("sc");
        dut_if.clr_cmd_rdy = 1'b0;

        // TX: single A5.
        snd_n = 1; snd_at[0] = -1; snd_b[0] = 8'hA5;
        tx_run();
        tx_check("tx_a5");
        check("tx_a5_rs_at", 32'(rs_pos[0]), 32'd159);

        // TX: A5, 11, 22 -> A5 then 22 back-to-back.
        snd_n = 3;
        snd_at[0] = -1; snd_b[0] = 8'hA5;
        snd_at[1] = 39; snd_b[1] = 8'h11;
        snd_at[2] = 79; snd_b[2] = 8'h22;
        tx_run();
        tx_check("tx_b2b");
        check("tx_b2b_rs_gap", 32'(rs_pos[1] - rs_pos[0]), 32'd160);

        // TX: request exactly on the final stop-bit cycle.
        rb0 = 8'($urandom); rb1 = 8'($urandom);
        snd_n = 2;
        snd_at[0] = -1;  snd_b[0] = rb0;
        snd_at[1] = 159; snd_b[1] = rb1;
        tx_run();
        tx_check("tx_edge");

        // TX: pending byte replaced by a request on the final cycle.
        snd_n = 3;
        snd_at[0] = -1;  snd_b[0] = 8'($urandom);
        snd_at[1] = 100; snd_b[1] = 8'($urandom);
        snd_at[2] = 159; snd_b[2] = 8'($urandom);
        tx_run();
        tx_check("tx_edge_pend");
        snd_n = 0;

        // Asynchronous reset mid-TX and mid-RX byte with cmd_rdy set.
        rx_byte(8'h5A, 1'b1);
        rx_byte(8'($urandom), 1'b1);
        rx_byte(8'($urandom), 1'b1);
        check_frame("pre_rst");
        dut_if.resp      = 8'h00;
        dut_if.send_resp = 1'b1;
        rx_line          = 1'b0;
        @(negedge clk);
        dut_if.send_resp = 1'b0;
        repeat (30) @(negedge clk);
        check("pre_rst_tx", 32'(tx_line), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_tx",      32'(tx_line),        32'h1);
        check("rst_async_cmd_rdy", 32'(dut_if.cmd_rdy), 32'h0);
        check("rst_async_cmd",     32'(dut_if.cmd),     32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        rst_n   = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        check("post_rst_tx_idle", 32'(tx_line), 32'h1);
        for (int b = 0; b < 3; b++) rx_byte(8'($urandom), 1'b1);
        check_frame("post_rst");

        // Reset after a lone opcode byte restarts frame assembly.
        rx_byte(8'hC3, 1'b1);
        check_frame("part");
        #2 rst_n = 1'b0;
        #1;
        check("rst2_cmd", 32'(dut_if.cmd), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int b = 0; b < 3; b++) rx_byte(8'($urandom), 1'b1);
        check_frame("post_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_wrapper.md
# uart_wrapper

Remote-link front end of the flight controller: receives 8N1 serial bytes on RX, assembles each 3-byte frame (opcode, data high, data low) into a command word presented to the command processor with a `cmd_rdy`/`clr_cmd_rdy` handshake, and serializes the one-byte response (`resp`/`send_resp`) back out on TX. It contains its own UART receiver and transmitter and sits between the board's serial pins and the command configuration block.

## Interface
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); must be even and ≥ 8
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- RX  input  1  serial in, idle high, asynchronous to clk
- TX  output  1  serial out, idle high
- cmd_rdy  output  1  complete 3-byte frame is available
- cmd  output  8  opcode (frame byte 0)
- data  output  16  {byte 1, byte 2}; byte 1 is the MSB
- clr_cmd_rdy  input  1  command processor has consumed the frame
- resp  input  8  response byte to transmit
- send_resp  input  1  one-cycle request to transmit `resp`
- resp_sent  output  1  one-cycle pulse when the response's stop bit completes

One clock, `clk`; reset `rst_n` is asynchronous, active-low.

## Operation
- Reset values: TX=1, cmd_rdy=0, cmd=8'h00, data=16'h0000, resp_sent=0; RX and frame FSMs in IDLE/WAIT_CMD; TX pending buffer empty.
- RX sync: RX is passed through two flops before any use. The synchronizer resets to 1.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized falling edge.
  - START waits BAUD_DIV/2 and samples. If the sample is 1, the edge was a glitch and the FSM returns to IDLE. If it is 0, go to DATA.
  - DATA samples 8 bits, LSB first, one every BAUD_DIV.
  - STOP samples after a further BAUD_DIV. A 1 accepts the byte. A 0 is a framing error: the byte is discarded and frame assembly is unaffected. Either way, return to IDLE.
- Frame FSM states: WAIT_CMD, WAIT_HI, WAIT_LO; each accepted byte advances it.
  - WAIT_CMD: load `cmd`, clear `cmd_rdy`, go to WAIT_HI.
  - WAIT_HI: load data[15:8], go to WAIT_LO.
  - WAIT_LO: load data[7:0], set `cmd_rdy`, go to WAIT_CMD.
- cmd_rdy rules:
  - Stays set until `clr_cmd_rdy` or until the first byte of the next frame.
  - If the frame completes in the same cycle as `clr_cmd_rdy`, set wins.
  - `cmd`/`data` do not change while cmd_rdy=1 except for the opcode load of a new frame, which also drops cmd_rdy in the same cycle.
- TX FSM states: IDLE, XMIT.
  - On `send_resp` in IDLE, latch `resp` into the 10-bit shift register {1, resp, 0} and go to XMIT.
  - XMIT shifts LSB first, one bit per BAUD_DIV.
  - After 10 bits: pulse resp_sent, then go to IDLE, or start the pending byte if one is queued.
- TX pending buffer: one entry.
  - `send_resp` during XMIT stores `resp` there.
  - A further `send_resp` before it drains overwrites it (last wins).
  - If `send_resp` coincides with the final bit completing, the new byte is queued and sent back-to-back; it is never lost.
- Reset mid-frame: all partial RX/TX progress is discarded and TX returns high immediately (asynchronous).

## Timing
- RX sample points: 2 cycles of sync latency, then BAUD_DIV/2 after the detected edge for the start bit, then every BAUD_DIV.
- A byte is accepted the cycle after its stop sample, 9.5·BAUD_DIV + ~3 cycles after the line's falling edge.
- `cmd_rdy` rises 1 cycle after the third byte is accepted.
- TX start bit is driven on the cycle after `send_resp`. Each bit lasts exactly BAUD_DIV cycles; a frame lasts 10·BAUD_DIV.
- `resp_sent` is high for 1 cycle, aligned with the last cycle of the stop bit.
- Back-to-back TX: the next start bit begins on the cycle immediately after the previous stop bit; there is no idle gap.
- RX bit counter and baud counter are sized for BAUD_DIV; neither wraps within a byte.

## Test plan
- BAUD_DIV=16, drive bytes 8'h02, 8'h12, 8'h34 on RX → cmd_rdy rises once, with cmd=8'h02 and data=16'h1234; it holds until clr_cmd_rdy, then drops the next cycle.
- Pulse send_resp with resp=8'hA5 → TX carries start bit, 1,0,1,0,0,1,0,1, stop bit at 16 cycles each; resp_sent pulses at cycle 160 after the start bit begins.
- Pulse send_resp with 8'hA5, then 8'h11 at cycle 40, then 8'h22 at cycle 80 → TX sends A5 then 22 back-to-back; two resp_sent pulses 160 cycles apart.
- Send a 3-byte frame whose byte 1 has stop bit = 0, then a valid byte 8'h56 → the bad byte is ignored; frame = {cmd, 8'h56, next byte}.
- RX low pulse of 4 cycles while idle → no byte accepted and frame state unchanged. Separately, a third byte completing in the same cycle as clr_cmd_rdy → cmd_rdy=1.
- Assert rst_n low mid-TX and mid-frame → TX=1 and cmd_rdy=0 immediately; the next full 3-byte frame after release decodes correctly.
